if_fifo: RTL and testbench



---
 rtl/if_fifo_if.sv | 26 ++
 rtl/if_fifo.sv | 71 +++++++
 tb/tb_if_fifo.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/if_fifo_if.sv
// Fetch-to-decode handshake bundle for the instruction fetch queue.
// The master is the fetch/decode side and the slave is the queue.
interface if_fifo_if #(
    parameter int unsigned CW = 3
);
    logic          in_valid;
    logic [31:0]   in_pc;
    logic [31:0]   in_inst;
    logic          in_ready;
    logic          out_valid;
    logic [31:0]   out_pc;
    logic [31:0]   out_inst;
    logic          out_ready;
    logic          flush;
    logic [CW-1:0] count;

    modport master (
        output in_valid, in_pc, in_inst, out_ready, flush,
        input  in_ready, out_valid, out_pc, out_inst, count
    );

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready, flush,
        output in_ready, out_valid, out_pc, out_inst, count
    );
endinterface

// File: rtl/if_fifo.sv
// Instruction fetch queue: buffers {pc, inst} pairs between fetch and decode,
// with flush-to-empty and a NOP presented to decode while empty.
module if_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic     clk,
    input  logic     rst,
    if_fifo_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = 64;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [DW-1:0] w_head;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Handshake outputs depend only on registered state and rst.
    assign bus.in_ready  = ~rst & ~w_full;
    assign bus.out_valid = ~w_empty;

    // Flush wins over both sides; a full queue refuses pushes even if popping.
    assign w_push = bus.in_valid & bus.in_ready & ~bus.flush;
    assign w_pop  = bus.out_valid & bus.out_ready & ~bus.flush;

    assign w_head       = r_mem[r_rp];
    assign bus.out_pc   = bus.out_valid ? w_head[63:32] : 32'h0;
    assign bus.out_inst = bus.out_valid ? w_head[31:0]  : 32'h0;
    assign bus.count    = r_count;

    // Storage needs no reset: stale entries are masked by out_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= {bus.in_pc, bus.in_inst};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fifo.sv
// Directed bench for if_fifo: reset, ordering, wrap, full/empty boundaries, flush.
`timescale 1ns/1ps
module tb_if_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    if_fifo_if #(.CW(3)) bus ();

    if_fifo #(.DEPTH(4), .CW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                          input logic rdy, input logic fl);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_inst   = inst;
        bus.out_ready = rdy;
        bus.flush     = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); else n_pass++;
        n_total++; if (bus.count !== 3'd0) $display("FAIL rst_count got=%0d exp=0", bus.count); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
        step();
        rst = 1'b0;
        step();
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rel_in_ready got=%b exp=1", bus.in_ready); else n_pass++;
        n_total++; if (bus.out_inst !== 32'h0) $display("FAIL rel_out_inst got=%h exp=0", bus.out_inst); else n_pass++;
        // Build count=2, then assert reset mid-cycle with a push in flight.
        set_in(1'b1, 32'h80, 32'hAAAA0080, 1'b0, 1'b0); step();
        set_in(1'b1, 32'h84, 32'hAAAA0084, 1'b0, 1'b0); step();
        n_total++; if (bus.count !== 3'd2) $display("FAIL pre_rst_count got=%0d exp=2", bus.count); else n_pass++;
        set_in(1'b1, 32'h88, 32'hAAAA0088, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_total++; if (bus.count !== 3'd0) $display("FAIL mid_rst_count got=%0d exp=0", bus.count); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL mid_rst_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
        n_total++; if (bus.out_pc !== 32'h0) $display("FAIL mid_rst_out_pc got=%h exp=0", bus.out_pc); else n_pass++;
        n_total++; if (bus.out_inst !== 32'h0) $display("FAIL mid_rst_out_inst got=%h exp=0", bus.out_inst); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL mid_rst_in_ready got=%b exp=0", bus.in_ready); else n_pass++;
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        step();
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL post_rst_in_ready got=%b exp=1", bus.in_ready); else n_pass++;
        n_total++; if (bus.out_inst !== 32'h0) $display("FAIL post_rst_out_inst got=%h exp=0", bus.out_inst); else n_pass++;
        n_total++; if (bus.count !== 3'd0) $display("FAIL post_rst_count got=%0d exp=0", bus.count); else n_pass++;
    endtask

    task automatic test_fill_drain();
        logic [31:0] pcs   [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        logic [31:0] insts [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, pcs[i], insts[i], 1'b0, 1'b0);
            step();
            n_total++; if (bus.count !== 3'(i + 1)) $display("FAIL fill_count%0d got=%0d exp=%0d", i, bus.count, i + 1); else n_pass++;
        end
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL full_in_ready got=%b exp=0", bus.in_ready); else n_pass++;
        set_in(1'b1, 32'h10, 32'h55555555, 1'b0, 1'b0);
        step();
        n_total++; if (bus.count !== 3'd4) $display("FAIL fifth_push_count got=%0d exp=4", bus.count); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            n_total++; if (bus.out_pc !== pcs[i]) $display("FAIL drain_pc%0d got=%h exp=%h", i, bus.out_pc, pcs[i]); else n_pass++;
            n_total++; if (bus.out_inst !== insts[i]) $display("FAIL drain_inst%0d got=%h exp=%h", i, bus.out_inst, insts[i]); else n_pass++;
            step();
        end
        n_total++; if (bus.count !== 3'd0) $display("FAIL drain_count got=%0d exp=0", bus.count); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL drain_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        for (int k = 0; k <= 20; k++) begin
            if (k < 20) set_in(1'b1, 32'(4 * k), 32'(4 * k) ^ 32'hA5A50000, 1'b1, 1'b0);
            else        set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            if (k > 0) begin
                exp_pc = 32'(4 * (k - 1));
                n_total++; if (bus.out_pc !== exp_pc) $display("FAIL stream_pc%0d got=%h exp=%h", k, bus.out_pc, exp_pc); else n_pass++;
                n_total++; if (bus.out_inst !== (exp_pc ^ 32'hA5A50000)) $display("FAIL stream_inst%0d got=%h exp=%h", k, bus.out_inst, exp_pc ^ 32'hA5A50000); else n_pass++;
            end
            step();
            n_total++; if (bus.count !== ((k < 20) ? 3'd1 : 3'd0)) $display("FAIL stream_count%0d got=%0d exp=%0d", k, bus.count, (k < 20) ? 1 : 0); else n_pass++;
        end
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_full_simul();
        logic [31:0] exp_pcs [4] = '{32'h44, 32'h48, 32'h4C, 32'h100};
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'(32'h40 + 4 * i), {16'hC0DE, 16'(32'h40 + 4 * i)}, 1'b0, 1'b0);
            step();
        end
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL fs_in_ready_full got=%b exp=0", bus.in_ready); else n_pass++;
        set_in(1'b1, 32'h100, 32'hC0DE0100, 1'b1, 1'b0);
        n_total++; if (bus.out_pc !== 32'h40) $display("FAIL fs_head got=%h exp=00000040", bus.out_pc); else n_pass++;
        step();
        n_total++; if (bus.count !== 3'd3) $display("FAIL fs_count got=%0d exp=3", bus.count); else n_pass++;
        n_total++; if (bus.out_pc !== 32'h44) $display("FAIL fs_head_after got=%h exp=00000044", bus.out_pc); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL fs_in_ready got=%b exp=1", bus.in_ready); else n_pass++;
        set_in(1'b1, 32'h100, 32'hC0DE0100, 1'b0, 1'b0);
        step();
        n_total++; if (bus.count !== 3'd4) $display("FAIL fs_repush_count got=%0d exp=4", bus.count); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            n_total++; if (bus.out_pc !== exp_pcs[i]) $display("FAIL fs_drain_pc%0d got=%h exp=%h", i, bus.out_pc, exp_pcs[i]); else n_pass++;
            n_total++; if (bus.out_inst !== {16'hC0DE, exp_pcs[i][15:0]}) $display("FAIL fs_drain_inst%0d got=%h exp=%h", i, bus.out_inst, {16'hC0DE, exp_pcs[i][15:0]}); else n_pass++;
            step();
        end
        n_total++; if (bus.count !== 3'd0) $display("FAIL fs_final_count got=%0d exp=0", bus.count); else n_pass++;
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'(32'h500 + 4 * i), 32'(32'hF0000500 + 4 * i), 1'b0, 1'b0);
            step();
        end
        n_total++; if (bus.count !== 3'd3) $display("FAIL fl_pre_count got=%0d exp=3", bus.count); else n_pass++;
        set_in(1'b1, 32'h200, 32'hF0000200, 1'b1, 1'b1);
        step();
        n_total++; if (bus.count !== 3'd0) $display("FAIL fl_count got=%0d exp=0", bus.count); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL fl_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
        n_total++; if (bus.out_pc !== 32'h0) $display("FAIL fl_out_pc got=%h exp=0", bus.out_pc); else n_pass++;
        n_total++; if (bus.out_inst !== 32'h0) $display("FAIL fl_out_inst got=%h exp=0", bus.out_inst); else n_pass++;
        set_in(1'b1, 32'h204, 32'hF0000204, 1'b0, 1'b0);
        step();
        n_total++; if (bus.out_valid !== 1'b1) $display("FAIL fl_push_valid got=%b exp=1", bus.out_valid); else n_pass++;
        n_total++; if (bus.out_pc !== 32'h204) $display("FAIL fl_push_pc got=%h exp=00000204", bus.out_pc); else n_pass++;
        n_total++; if (bus.out_inst !== 32'hF0000204) $display("FAIL fl_push_inst got=%h exp=f0000204", bus.out_inst); else n_pass++;
        n_total++; if (bus.count !== 3'd1) $display("FAIL fl_push_count got=%0d exp=1", bus.count); else n_pass++;
        set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        n_total++; if (bus.count !== 3'd0) $display("FAIL fl_pop_count got=%0d exp=0", bus.count); else n_pass++;
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_empty_simul();
        set_in(1'b1, 32'h300, 32'hE0000300, 1'b1, 1'b0);
        step();
        n_total++; if (bus.count !== 3'd1) $display("FAIL es_count got=%0d exp=1", bus.count); else n_pass++;
        n_total++; if (bus.out_pc !== 32'h300) $display("FAIL es_out_pc got=%h exp=00000300", bus.out_pc); else n_pass++;
        n_total++; if (bus.out_inst !== 32'hE0000300) $display("FAIL es_out_inst got=%h exp=e0000300", bus.out_inst); else n_pass++;
        set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL es_drain_valid got=%b exp=0", bus.out_valid); else n_pass++;
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_stream();
        test_full_simul();
        test_flush();
        test_empty_simul();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
